// File: rtl/imm_sched.sv
// Immediate decode/extend stage with a 2-entry FIFO toward execute.
// Optional macro IMM_SCHED_LUI_EN enables the LUI extension mode for opcode 0x0F.
module imm_sched (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_imm,
    output logic [1:0]  out_mode
);

    localparam logic [1:0] S_EMPTY = 2'd0;
    localparam logic [1:0] S_ONE   = 2'd1;
    localparam logic [1:0] S_FULL  = 2'd2;

    localparam logic [1:0] M_NONE = 2'b00;
    localparam logic [1:0] M_SIGN = 2'b01;
    localparam logic [1:0] M_ZERO = 2'b10;
    localparam logic [1:0] M_LUI  = 2'b11;

    logic [1:0]  state_q, state_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [31:0] imm_q  [2];
    logic [1:0]  mode_q [2];

    logic        push, pop;
    logic [1:0]  dec_mode;
    logic [31:0] dec_imm;

    function automatic logic [1:0] decode_mode(input logic [5:0] op);
        logic [1:0] m;
        m = M_NONE;
        if (op >= 6'h0C && op <= 6'h0E) begin
            m = M_ZERO;
        end else if (op == 6'h0F) begin
`ifdef IMM_SCHED_LUI_EN
            m = M_LUI;
`else
            m = M_ZERO;
`endif
        end else if (op == 6'h01 || (op >= 6'h04 && op <= 6'h0B) ||
                     (op >= 6'h20 && op <= 6'h2B)) begin
            m = M_SIGN;
        end
        return m;
    endfunction

    function automatic logic [31:0] extend_imm(input logic [1:0] m, input logic [15:0] imm);
        logic [31:0] r;
        case (m)
            M_SIGN:  r = {{16{imm[15]}}, imm};
            M_ZERO:  r = {16'h0000, imm};
            M_LUI:   r = {imm, 16'h0000};
            default: r = 32'h0000_0000;
        endcase
        return r;
    endfunction

    assign in_ready  = (state_q != S_FULL);
    assign out_valid = (state_q == S_ONE) || (state_q == S_FULL);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    assign dec_mode = decode_mode(instr[31:26]);
    assign dec_imm  = extend_imm(dec_mode, instr[15:0]);

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            state_d  = S_EMPTY;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push) wr_ptr_d = ~wr_ptr_q;
            if (pop)  rd_ptr_d = ~rd_ptr_q;
            case (state_q)
                S_EMPTY: if (push) state_d = S_ONE;
                S_ONE: begin
                    if (push && !pop)      state_d = S_FULL;
                    else if (pop && !push) state_d = S_EMPTY;
                end
                S_FULL:  if (pop) state_d = S_ONE;
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_EMPTY;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Payload storage is unreset; its visibility is governed solely by state_q.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            imm_q[wr_ptr_q]  <= dec_imm;
            mode_q[wr_ptr_q] <= dec_mode;
        end
    end

    assign out_imm  = out_valid ? imm_q[rd_ptr_q]  : 32'h0000_0000;
    assign out_mode = out_valid ? mode_q[rd_ptr_q] : M_NONE;

endmodule

// File: tb/tb_imm_sched.sv
// Table-driven bench for imm_sched with an in-order scoreboard of expected heads.
module tb_imm_sched;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] instr = 32'h0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_imm;
    logic [1:0]  out_mode;

    imm_sched dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .instr    (instr),
        .flush    (flush),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_imm  (out_imm),
        .out_mode (out_mode)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [1:0]  mode;
        logic [31:0] imm;
    } vec_t;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] imm;
    } exp_t;

    localparam int NV = 13;
    vec_t tbl [NV];
    exp_t sb [$];
    int   cur_idx = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic set_in(input int idx);
        cur_idx = idx;
        instr   = tbl[idx].instr;
    endtask

    // Compare mid-cycle against the model, update the model, then advance one edge.
    task automatic cycle();
        exp_t e;
        chk("out_valid", {31'b0, out_valid}, {31'b0, (sb.size() != 0)});
        chk("in_ready", {31'b0, in_ready}, {31'b0, (sb.size() < 2)});
        if (sb.size() != 0) begin
            chk("head_imm", out_imm, sb[0].imm);
            chk("head_mode", {30'b0, out_mode}, {30'b0, sb[0].mode});
        end else begin
            chk("idle_imm", out_imm, 32'h0);
            chk("idle_mode", {30'b0, out_mode}, 32'h0);
        end
        if (flush) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready && sb.size() != 0) void'(sb.pop_front());
            if (in_valid && in_ready) begin
                e.mode = tbl[cur_idx].mode;
                e.imm  = tbl[cur_idx].imm;
                sb.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        int guard;
        logic acc;

        tbl[0]  = '{32'h2008FFFC, 2'b01, 32'hFFFFFFFC};
        tbl[1]  = '{32'h3508FFFC, 2'b10, 32'h0000FFFC};
`ifdef IMM_SCHED_LUI_EN
        tbl[2]  = '{32'h3C081234, 2'b11, 32'h12340000};
`else
        tbl[2]  = '{32'h3C081234, 2'b10, 32'h00001234};
`endif
        tbl[3]  = '{32'h00000020, 2'b00, 32'h00000000};
        tbl[4]  = '{32'h10008000, 2'b01, 32'hFFFF8000};
        tbl[5]  = '{32'h30007FFF, 2'b10, 32'h00007FFF};
        tbl[6]  = '{32'h8C008001, 2'b01, 32'hFFFF8001};
        tbl[7]  = '{32'hB0001234, 2'b00, 32'h00000000};
        tbl[8]  = '{32'h04001234, 2'b01, 32'h00001234};
        tbl[9]  = '{32'h08008000, 2'b00, 32'h00000000};
        tbl[10] = '{32'h38008000, 2'b10, 32'h00008000};
        tbl[11] = '{32'hAC00FFFF, 2'b01, 32'hFFFFFFFF};
        tbl[12] = '{32'h0C00FFFF, 2'b00, 32'h00000000};

        // Reset state
        #2 rst = 1'b1;
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_out_imm", out_imm, 32'h0);
        chk("rst_out_mode", {30'b0, out_mode}, 32'h0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Single-entry decode of each table vector, one-cycle latency
        for (int i = 0; i < NV; i++) begin
            set_in(i);
            in_valid  = 1'b1;
            out_ready = 1'b0;
            cycle();
            in_valid = 1'b0;
            chk("vec_valid", {31'b0, out_valid}, 32'h1);
            chk("vec_mode", {30'b0, out_mode}, {30'b0, tbl[i].mode});
            chk("vec_imm", out_imm, tbl[i].imm);
            out_ready = 1'b1;
            cycle();
            out_ready = 1'b0;
        end
        cycle();

        // Back-pressure: third instruction held until the sink drains
        k = 0;
        guard = 0;
        in_valid = 1'b1;
        while (k < 3 && guard < 20) begin
            set_in(k);
            acc = in_ready;
            if (k == 2 && !out_ready) chk("bp_in_ready", {31'b0, in_ready}, 32'h0);
            cycle();
            if (acc) k++;
            guard++;
            if (guard == 4) out_ready = 1'b1;
        end
        chk("bp_all_accepted", k, 3);
        in_valid = 1'b0;
        repeat (3) cycle();
        out_ready = 1'b0;

        // Simultaneous push/pop in ONE for four cycles
        set_in(3);
        in_valid = 1'b1;
        cycle();
        out_ready = 1'b1;
        for (int j = 0; j < 4; j++) begin
            set_in(4 + j);
            cycle();
            chk("pp_in_ready", {31'b0, in_ready}, 32'h1);
            chk("pp_out_valid", {31'b0, out_valid}, 32'h1);
            chk("pp_depth", sb.size(), 1);
        end
        in_valid = 1'b0;
        repeat (2) cycle();
        out_ready = 1'b0;

        // Flush from FULL while an instruction is offered
        in_valid = 1'b1;
        set_in(5);
        cycle();
        set_in(6);
        cycle();
        chk("fl_full", {31'b0, in_ready}, 32'h0);
        set_in(0);
        flush = 1'b1;
        cycle();
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_out_valid", {31'b0, out_valid}, 32'h0);
        chk("fl_in_ready", {31'b0, in_ready}, 32'h1);
        out_ready = 1'b1;
        repeat (2) cycle();
        out_ready = 1'b0;

        // Asynchronous reset from FULL, then immediate reuse
        in_valid = 1'b1;
        set_in(10);
        cycle();
        set_in(11);
        cycle();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("ar_out_valid", {31'b0, out_valid}, 32'h0);
        chk("ar_out_imm", out_imm, 32'h0);
        chk("ar_out_mode", {30'b0, out_mode}, 32'h0);
        chk("ar_in_ready", {31'b0, in_ready}, 32'h1);
        sb.delete();
        #1 rst = 1'b0;
        set_in(1);
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk("ar_reuse_valid", {31'b0, out_valid}, 32'h1);
        chk("ar_reuse_imm", out_imm, 32'h0000FFFC);
        out_ready = 1'b1;
        repeat (2) cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_sched.md
IMM_SCHED -- requirements
Module: imm_sched

Interface
No parameters.
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, asynchronous, active-high.
REQ-003 in_valid  input  1  decode stage presents an instruction.
REQ-004 in_ready  output  1  block can accept; transfer occurs when in_valid && in_ready at a rising edge.
REQ-005 instr  input  32  instruction word; opcode = instr[31:26], immediate = instr[15:0].
REQ-006 flush  input  1  discard all buffered entries (branch or exception redirect).
REQ-007 out_valid  output  1  head entry is valid for the execute stage.
REQ-008 out_ready  input  1  execute stage consumes; pop when out_valid && out_ready.
REQ-009 out_imm  output  32  extended immediate of the head entry.
REQ-010 out_mode  output  2  extension mode of the head entry: 00 NONE, 01 SIGN, 10 ZERO, 11 LUI.

Function
REQ-011 Mode decode SHALL be: opcodes 0x0C-0x0E (ANDI/ORI/XORI) -> ZERO; 0x0F (LUI) -> LUI; 0x01, 0x04-0x0B, 0x20-0x2B -> SIGN; all others -> NONE.
REQ-012 Extension SHALL be: SIGN -> {16{imm[15]}, imm}; ZERO -> {16'h0, imm}; LUI -> {imm, 16'h0}; NONE -> 32'h0.
REQ-013 Decode and extension SHALL be computed on the accept cycle and stored; out_imm/out_mode SHALL come from registers only (no combinational path from instr to outputs).
REQ-014 The block SHALL hold a 2-entry FIFO with states EMPTY (0), ONE (1), FULL (2).
REQ-015 Latency: an entry accepted into EMPTY at edge N SHALL show out_valid=1 after edge N.
REQ-016 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL; it SHALL be derived from state only, never from out_ready.
REQ-017 Transitions: push only -> count+1; pop only -> count-1; push and pop in the same cycle (ONE) -> stays ONE, new entry becomes head after old head pops.
REQ-018 out_valid SHALL be 1 exactly in ONE and FULL; out_imm/out_mode SHALL stay stable while out_valid && !out_ready.
REQ-019 Entries SHALL leave in acceptance order; read/write pointers SHALL wrap 1 -> 0.
REQ-020 flush=1 SHALL force EMPTY at the next edge, overriding any push or pop in that cycle; an instruction offered during flush SHALL be dropped.
REQ-021 out_imm/out_mode SHALL read 32'h0 / 2'b00 whenever out_valid=0.

Reset
REQ-022 rst=1 SHALL immediately (asynchronously) force EMPTY, pointers 0, out_valid=0, out_imm=32'h0, out_mode=2'b00, in_ready=1.
REQ-023 rst asserted mid-operation SHALL discard all buffered entries; no partial entry SHALL survive.
REQ-024 rst deassertion SHALL be sampled synchronously; first accept possible at the first edge with rst=0.

Configuration
REQ-025 Macro IMM_SCHED_LUI_EN: defined -> opcode 0x0F decodes to LUI and produces {imm,16'h0}; undefined -> opcode 0x0F decodes to ZERO, produces {16'h0,imm}, and mode 11 SHALL never be output.

Verification
REQ-026 Reset, then instr=0x2008FFFC (ADDI) accepted -> next cycle out_valid=1, out_mode=01, out_imm=0xFFFFFFFC.
REQ-027 instr=0x3508FFFC (ORI) -> out_mode=10, out_imm=0x0000FFFC; instr=0x3C081234 (LUI) -> with macro 11/0x12340000, without 10/0x00001234.
REQ-028 out_ready=0, push 3 instrs back-to-back -> in_ready=0 after second push, third held by source; then out_ready=1 -> entries pop in order, third accepted.
REQ-029 State ONE, simultaneous push and pop for 4 cycles with out_ready=1 -> state stays ONE, outputs follow input sequence with 1-cycle lag, no drop or duplicate.
REQ-030 State FULL, flush=1 with in_valid=1 -> next cycle out_valid=0, in_ready=1, offered instruction absent from output.
REQ-031 State FULL, rst pulsed between edges -> out_valid=0, out_imm=0 immediately, before next edge.
